alu_share_arb: RTL and testbench

Two-port arbiter and sequencer that shares one combinational `ALU_32` instance between two requesters. Typical requesters are the integer pipeline and a microcoded helper. The block accepts one operation at a time over a valid/ready handshake, registers the operands into the ALU, and captures the result. It returns the result to the granted requester over a held response handshake. Grant order is round-robin.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/ALU_32.sv | 30 +++
 rtl/alu_share_arb_rr_arb2.sv | 42 ++++
 rtl/alu_share_arb.sv | 121 ++++++++++++
 tb/tb_alu_share_arb.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes, legality helpers and sequencer state encoding
// used by the ALU-sharing arbiter and its requesters.
package alu_pkg;

  localparam logic [5:0] ALU_ADD = 6'd32;
  localparam logic [5:0] ALU_SUB = 6'd34;
  localparam logic [5:0] ALU_AND = 6'd36;
  localparam logic [5:0] ALU_OR  = 6'd37;
  localparam logic [5:0] ALU_SLT = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic alu_sel_legal(input logic [5:0] sel);
    logic ok;
    case (sel)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: ok = 1'b1;
      default:                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ALU_32.sv
// 32-bit combinational ALU: add/sub share one adder (sel[1] inverts B and
// supplies carry-in), sel[2:0] = 100/101 select AND/OR.
module ALU_32 (
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  sel,
  output logic [31:0] y
);

  logic [31:0] w_b_eff;
  logic [31:0] w_sum;

  assign w_b_eff = sel[1] ? ~b : b;
  assign w_sum   = a + w_b_eff + {31'd0, sel[1]};

  always_comb begin
    y = w_sum;
    if (reset) begin
      y = '0;
    end else begin
      case (sel[2:0])
        3'b100:  y = a & b;
        3'b101:  y = a | b;
        default: y = w_sum;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to r_prio, and
// the pointer flips to the other requester after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  logic r_prio;
  logic w_xfer;

  always_comb begin
    o_grant     = 2'b00;
    o_grant_idx = 1'b0;
    if (i_en) begin
      if (i_valid == 2'b11) begin
        o_grant_idx = r_prio;
        o_grant     = r_prio ? 2'b10 : 2'b01;
      end else if (i_valid[1]) begin
        o_grant_idx = 1'b1;
        o_grant     = 2'b10;
      end else if (i_valid[0]) begin
        o_grant     = 2'b01;
      end
    end
  end

  // A grant is only issued to a valid requester, so a grant is a transfer.
  assign w_xfer = |o_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (w_xfer) begin
      r_prio <= ~o_grant_idx;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU_32 between two requesters: round-robin accept in IDLE,
// registered operands in EXEC, held one-hot response in RESP.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [W-1:0]    req_a0,
  input  logic [W-1:0]    req_b0,
  input  logic [W-1:0]    req_a1,
  input  logic [W-1:0]    req_b1,
  input  logic [5:0]      req_sel0,
  input  logic [5:0]      req_sel1,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_err,
  output logic            busy
);

  state_t      r_state;
  state_t      w_state_next;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [5:0]  r_sel;
  logic        r_gnt;
  logic [W-1:0] r_rsp_data;
  logic        r_rsp_err;

  logic [1:0]  w_grant;
  logic        w_grant_idx;
  logic        w_xfer;
  logic        w_legal;
  logic [W-1:0] w_alu_y;
  logic [W-1:0] w_result;

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_en        (r_state == ST_IDLE),
    .i_valid     (req_valid),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  ALU_32 u_alu (
    .reset (1'b0),
    .a     (r_a),
    .b     (r_b),
    .sel   (r_sel),
    .y     (w_alu_y)
  );

  assign w_xfer    = |w_grant;
  assign req_ready = w_grant;
  assign w_legal   = alu_sel_legal(r_sel);

  // slt reports the sign of A-B, which the ALU already computes for sel=42.
  always_comb begin
    w_result = '0;
    if (w_legal) begin
      w_result = (r_sel == ALU_SLT) ? {{(W-1){1'b0}}, w_alu_y[W-1]} : w_alu_y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_xfer) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (rsp_ready[r_gnt]) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sel      <= '0;
      r_gnt      <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_a   <= w_grant_idx ? req_a1   : req_a0;
        r_b   <= w_grant_idx ? req_b1   : req_b0;
        r_sel <= w_grant_idx ? req_sel1 : req_sel0;
        r_gnt <= w_grant_idx;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= w_result;
        r_rsp_err  <= ~w_legal;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp_valid
      assign rsp_valid[gi] = (r_state == ST_RESP) && (r_gnt == 1'(gi));
    end
  endgenerate

  assign rsp_data = r_rsp_data;
  assign rsp_err  = r_rsp_err;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed plus short random bench for alu_share_arb; expected responses are
// queued at grant time and popped when the response appears.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] a0, b0, a1, b1, rsp_data;
  logic [5:0]  sel0, sel1;
  logic        rsp_err, busy;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (a0),
    .req_b0    (b0),
    .req_a1    (a1),
    .req_b1    (b1),
    .req_sel0  (sel0),
    .req_sel1  (sel1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  function automatic exp_t model(input int p, input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] sel);
    exp_t        e;
    logic [31:0] d;
    d      = a - b;
    e.port = p;
    e.err  = 1'b0;
    case (sel)
      6'd32:   e.data = a + b;
      6'd34:   e.data = d;
      6'd36:   e.data = a & b;
      6'd37:   e.data = a | b;
      6'd42:   e.data = {31'd0, d[31]};
      default: begin e.data = 32'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] sel);
    if (p == 0) begin a0 = a; b0 = b; sel0 = sel; end
    else        begin a1 = a; b1 = b; sel1 = sel; end
    req_valid[p] = 1'b1;
  endtask

  task automatic wait_xfer(input int p);
    logic [1:0] oh;
    int         k;
    oh = (p == 0) ? 2'b01 : 2'b10;
    k  = 0;
    #1;
    while (req_ready == 2'b00 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready", {30'd0, req_ready}, {30'd0, oh});
    if (p == 0) sb.push_back(model(0, a0, b0, sel0));
    else        sb.push_back(model(1, a1, b1, sel1));
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
  endtask

  task automatic collect(input int stall);
    exp_t       e;
    logic [1:0] oh;
    @(negedge clk);
    chk("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    e  = sb.pop_front();
    oh = (e.port == 0) ? 2'b01 : 2'b10;
    chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    $display("txn port=%0d data=%08h err=%0d stall=%0d", e.port, rsp_data, rsp_err, stall);
    rsp_ready = ~oh;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
      chk("stall_rsp_data", rsp_data, e.data);
      chk("stall_req_ready", {30'd0, req_ready}, 32'd0);
    end
    rsp_ready = oh;
    @(posedge clk);
    #1 rsp_ready = 2'b00;
    chk("done_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_idle_reset_vals();
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] codes [7];
    int         p;
    codes = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd63};
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; sel0 = '0; sel1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle_reset_vals();

    // Contention from reset: port 0 first, then port 1, then port 0 again.
    set_req(0, 32'd10, 32'd20, 6'd32);
    set_req(1, 32'd100, 32'd1, 6'd34);
    wait_xfer(0); collect(0);
    wait_xfer(1); collect(0);
    set_req(0, 32'd1, 32'd2, 6'd32);
    set_req(1, 32'hF0, 32'h3C, 6'd36);
    wait_xfer(0); collect(0);
    wait_xfer(1); collect(0);

    // Single add, then sub/slt on port 1.
    set_req(0, 32'd5, 32'd7, 6'd32); wait_xfer(0); collect(0);
    set_req(1, 32'd3, 32'd5, 6'd34); wait_xfer(1); collect(0);
    set_req(1, 32'd3, 32'd5, 6'd42); wait_xfer(1); collect(0);
    set_req(1, 32'd5, 32'd3, 6'd42); wait_xfer(1); collect(0);

    // Response stalls while the other port waits.
    set_req(0, 32'hF0F0_1234, 32'h0FF0_FF00, 6'd36);
    set_req(1, 32'hF0F0_1234, 32'h0FF0_FF00, 6'd37);
    wait_xfer(0); collect(5);
    wait_xfer(1); collect(5);

    // Illegal codes, then a legal op clears the error.
    set_req(1, 32'hFFFF_FFFF, 32'd1, 6'd0);  wait_xfer(1); collect(0);
    set_req(0, 32'hFFFF_FFFF, 32'd1, 6'd33); wait_xfer(0); collect(1);
    set_req(0, 32'hFFFF_FFFF, 32'd1, 6'd32); wait_xfer(0); collect(0);

    // Reset during EXEC discards the op and clears prio (left at 1 here).
    set_req(0, 32'd9, 32'd9, 6'd32);
    wait_xfer(0);
    void'(sb.pop_back());
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_reset_vals();
    end
    set_req(0, 32'd40, 32'd2, 6'd34);
    set_req(1, 32'h8000_0000, 32'd1, 6'd42);
    wait_xfer(0); collect(0);
    wait_xfer(1); collect(0);

    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(0, 1));
      set_req(p, $urandom, $urandom, codes[$urandom_range(0, 6)]);
      wait_xfer(p);
      collect(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
